draw_pair_reader: RTL and testbench

// - Read-side partner of the draw-region address counter. Scans the dual-port frame RAM region that
//   the writer fills (word addresses 4096..6143 by default), one even/odd address pair per access.
// - Streams the words out as a valid/ready byte stream, even word first, to the display/compare path.
// - Drives both RAM read ports; RAM has 1-cycle synchronous read latency.

---
 rtl/draw_pair_reader.sv | 158 +++++++++++++++
 tb/tb_draw_pair_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_pair_reader.sv
// rtl/draw_pair_reader.sv - frame RAM draw-region pair scanner with valid/ready byte stream out
//
// Scans pairs BASE_PAIR .. BASE_PAIR+NUM_PAIRS-1 of a dual-port RAM (1-cycle read latency),
// reading the even word on port A and the odd word on port B, and streams them even-first.
// Optional build macro: DRAW_READER_CHECKSUM_EN adds a running XOR checksum output.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   start               launch one scan (honoured in IDLE only)
//   rd_en               RAM read strobe for both ports
//   addr_a, addr_b      RAM port addresses (even / odd word of the current pair)
//   q_a, q_b            RAM read data, valid the cycle after rd_en
//   out_data/valid/ready/last   byte stream to the display/compare path
//   busy, done          scan in progress / one-cycle completion pulse
//   checksum            (DRAW_READER_CHECKSUM_EN only) XOR of words transferred this scan

module draw_pair_reader #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int BASE_PAIR = 2048,
  parameter int NUM_PAIRS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] q_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef DRAW_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int CNT_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] FIRST_PAIR = CNT_W'(BASE_PAIR);
  localparam logic [CNT_W-1:0] LAST_PAIR  = CNT_W'(BASE_PAIR + NUM_PAIRS - 1);

  // The pair counter must never wrap inside a scan.
  generate
    if (BASE_PAIR + NUM_PAIRS > (1 << (ADDR_W - 1))) begin : g_range_err
      $error("draw_pair_reader: BASE_PAIR+NUM_PAIRS exceeds 2**(ADDR_W-1)");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LATCH,
    S_SEND_A,
    S_SEND_B,
    S_DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [DATA_W-1:0]  hold_a;
  logic [DATA_W-1:0]  hold_b;
  logic               is_last;

  assign is_last = (cnt == LAST_PAIR);
  assign busy    = (state != S_IDLE);

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    rd_en      = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_REQ;
          cnt_next   = FIRST_PAIR;
        end
      end
      S_REQ: begin
        rd_en      = 1'b1;
        next_state = S_LATCH;
      end
      S_LATCH: begin
        next_state = S_SEND_A;
      end
      S_SEND_A: begin
        out_valid = 1'b1;
        out_data  = hold_a;
        if (out_ready) next_state = S_SEND_B;
      end
      S_SEND_B: begin
        out_valid = 1'b1;
        out_data  = hold_b;
        out_last  = is_last;
        if (out_ready) begin
          if (is_last) begin
            next_state = S_DONE;
          end else begin
            next_state = S_REQ;
            cnt_next   = cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= FIRST_PAIR;
      addr_a <= {FIRST_PAIR, 1'b0};
      addr_b <= {FIRST_PAIR, 1'b1};
      hold_a <= '0;
      hold_b <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      // Addresses are loaded on the way into REQ so they are already registered
      // during the single rd_en cycle, and then simply hold.
      if (next_state == S_REQ) begin
        addr_a <= {cnt_next, 1'b0};
        addr_b <= {cnt_next, 1'b1};
      end
      if (state == S_LATCH) begin
        hold_a <= q_a;
        hold_b <= q_b;
      end
    end
  end

`ifdef DRAW_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (state == S_IDLE && start) begin
      checksum <= '0;
    end else if (out_valid && out_ready) begin
      checksum <= checksum ^ out_data;
    end
  end
`endif

endmodule

// File: tb/tb_draw_pair_reader.sv
// tb/tb_draw_pair_reader.sv - directed self-checking bench for draw_pair_reader

module tb_draw_pair_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rd_en;
  logic [13:0] addr_a;
  logic [13:0] addr_b;
  logic [7:0]  q_a = 8'h00;
  logic [7:0]  q_b = 8'h00;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef DRAW_READER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int tests  = 0;
  int failed = 0;

  // RAM content pattern: 0 q=addr[7:0]; 1 odd words 0x5A; 2 even 0xA5 odd 0x5A;
  // 3 only addr 4096 holds 0x01, everything else 0.
  int ram_mode = 0;

  // Scan statistics filled by run_scan
  int n_words, n_bad_data, n_bad_last, n_last, n_rd, n_addr_bad, n_done;
  int n_stall_bad, n_busy_bad, done_cyc, first_valid_cyc;

  draw_pair_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_en     (rd_en),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .q_a       (q_a),
    .q_b       (q_b),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef DRAW_READER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_q(input logic [13:0] a);
    case (ram_mode)
      0:       return a[7:0];
      1:       return a[0] ? 8'h5A : a[7:0];
      2:       return a[0] ? 8'h5A : 8'hA5;
      default: return (a == 14'd4096) ? 8'h01 : 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      q_a <= ram_q(addr_a);
      q_b <= ram_q(addr_b);
    end
  end

  // Runs one scan from a start pulse. rmode 1 = random out_ready.
  // restart_words >= 0: pulse start again when that many words have gone.
  // abort_words >= 0: assert reset while the word with that index is presented.
  task automatic run_scan(input int rmode, input int restart_words, input int abort_words);
    int          cyc;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;
    logic [13:0] a;
    logic        restarted;
    n_words = 0; n_bad_data = 0; n_bad_last = 0; n_last = 0; n_rd = 0; n_addr_bad = 0;
    n_done = 0; n_stall_bad = 0; n_busy_bad = 0; done_cyc = -1; first_valid_cyc = -1;
    prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0; restarted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (restart_words >= 0 && !restarted && n_words == restart_words && out_valid) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (rd_en) begin
        a = 14'(4096 + 2 * n_rd);
        if (addr_a !== a || addr_b !== (a | 14'd1)) n_addr_bad++;
        n_rd++;
      end
      if (busy !== (done_cyc < 0)) n_busy_bad++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
        n_stall_bad++;
      if (abort_words >= 0 && n_words == abort_words && out_valid) begin
        reset = 1'b0;
        break;
      end
      out_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        if (out_data !== ram_q(14'(4096 + n_words))) n_bad_data++;
        if (out_last !== (n_words == 2047)) n_bad_last++;
        if (out_last) n_last++;
        n_words++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done_cyc >= 0 && cyc > done_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    tests++; if (rd_en !== 1'b0) begin failed++; $display("FAIL reset_rd_en: got %0b want 0", rd_en); end
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %0b want 0", done); end
    tests++; if (addr_a !== 14'd4096) begin failed++; $display("FAIL reset_addr_a: got %0d want 4096", addr_a); end
    tests++; if (addr_b !== 14'd4097) begin failed++; $display("FAIL reset_addr_b: got %0d want 4097", addr_b); end
    tests++; if (out_data !== 8'h00) begin failed++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
  endtask

  task automatic test_full_scan;
    ram_mode = 0;
    run_scan(0, -1, -1);
    tests++; if (n_words !== 2048) begin failed++; $display("FAIL full_words: got %0d want 2048", n_words); end
    tests++; if (n_bad_data !== 0) begin failed++; $display("FAIL full_data: got %0d bad words want 0", n_bad_data); end
    tests++; if (n_bad_last !== 0 || n_last !== 1) begin failed++; $display("FAIL full_last: got %0d bad/%0d seen want 0/1", n_bad_last, n_last); end
    tests++; if (n_done !== 1) begin failed++; $display("FAIL full_done_count: got %0d want 1", n_done); end
    tests++; if (n_rd !== 1024 || n_addr_bad !== 0) begin failed++; $display("FAIL full_rd: got %0d reads %0d bad addr want 1024/0", n_rd, n_addr_bad); end
    // Cycle 1 is the REQ of pair 0, SEND_A lands on cycle 3.
    tests++; if (first_valid_cyc !== 3) begin failed++; $display("FAIL full_first_valid: got cycle %0d want 3", first_valid_cyc); end
    // 4 cycles per pair for 1024 pairs, DONE follows the last SEND_B.
    tests++; if (done_cyc !== 4097) begin failed++; $display("FAIL full_done_cycle: got %0d want 4097", done_cyc); end
    tests++; if (n_busy_bad !== 0) begin failed++; $display("FAIL full_busy: got %0d bad cycles want 0", n_busy_bad); end
  endtask

  task automatic test_random_ready;
    ram_mode = 0;
    run_scan(1, -1, -1);
    tests++; if (n_words !== 2048) begin failed++; $display("FAIL rnd_words: got %0d want 2048", n_words); end
    tests++; if (n_bad_data !== 0) begin failed++; $display("FAIL rnd_data: got %0d bad words want 0", n_bad_data); end
    tests++; if (n_stall_bad !== 0) begin failed++; $display("FAIL rnd_stall_stable: got %0d bad stalls want 0", n_stall_bad); end
    tests++; if (n_rd !== 1024 || n_addr_bad !== 0) begin failed++; $display("FAIL rnd_rd: got %0d reads %0d bad addr want 1024/0", n_rd, n_addr_bad); end
    tests++; if (n_done !== 1 || n_bad_last !== 0) begin failed++; $display("FAIL rnd_done_last: got %0d done %0d bad last want 1/0", n_done, n_bad_last); end
  endtask

  task automatic test_restart_ignored;
    ram_mode = 0;
    run_scan(0, 200, -1);
    tests++; if (n_words !== 2048 || n_bad_data !== 0) begin failed++; $display("FAIL restart_seq: got %0d words %0d bad want 2048/0", n_words, n_bad_data); end
    tests++; if (n_rd !== 1024 || n_addr_bad !== 0) begin failed++; $display("FAIL restart_rd: got %0d reads %0d bad addr want 1024/0", n_rd, n_addr_bad); end
    tests++; if (done_cyc !== 4097) begin failed++; $display("FAIL restart_done_cycle: got %0d want 4097", done_cyc); end
  endtask

  task automatic test_reset_abort;
    int dones;
    ram_mode = 0;
    run_scan(0, -1, 1001);
    #1;
    tests++; if (reset !== 1'b0) begin failed++; $display("FAIL abort_reached: reset %0b want 0", reset); end
    tests++; if ({rd_en, out_valid, out_last, busy, done} !== 5'b0) begin failed++; $display("FAIL abort_ctrl: got %05b want 00000", {rd_en, out_valid, out_last, busy, done}); end
    tests++; if (addr_a !== 14'd4096 || addr_b !== 14'd4097 || out_data !== 8'h00) begin failed++; $display("FAIL abort_data: got a=%0d b=%0d d=%0h want 4096 4097 0", addr_a, addr_b, out_data); end
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    tests++; if (dones !== 0 || n_done !== 0) begin failed++; $display("FAIL abort_no_done: got %0d pulses want 0", dones + n_done); end
    run_scan(0, -1, -1);
    tests++; if (n_words !== 2048 || n_bad_data !== 0 || n_addr_bad !== 0) begin failed++; $display("FAIL abort_rescan: got %0d words %0d bad %0d bad addr want 2048/0/0", n_words, n_bad_data, n_addr_bad); end
    tests++; if (n_done !== 1) begin failed++; $display("FAIL abort_rescan_done: got %0d want 1", n_done); end
  endtask

`ifdef DRAW_READER_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] want [4];
    int         modes [4];
    want[0] = 8'h01; modes[0] = 3;
    want[1] = 8'h00; modes[1] = 0;
    want[2] = 8'h00; modes[2] = 1;
    want[3] = 8'h00; modes[3] = 2;
    for (int i = 0; i < 4; i++) begin
      ram_mode = modes[i];
      run_scan(0, -1, -1);
      tests++; if (checksum !== want[i] || n_bad_data !== 0) begin failed++; $display("FAIL checksum_mode%0d: got %0h (%0d bad words) want %0h", modes[i], checksum, n_bad_data, want[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_random_ready();
    test_restart_ignored();
    test_reset_abort();
`ifdef DRAW_READER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
